// File: rtl/square_pkg.sv
// Shared state encoding and elaboration helpers for the square_seq digit-serial multiplier.
package square_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int num_digits(input int bitwidth, input int digit);
        return bitwidth / digit;
    endfunction

    // One extra bit so the count can reach N without wrapping.
    function automatic int count_width(input int bitwidth, input int digit);
        return $clog2(bitwidth / digit) + 1;
    endfunction

    function automatic bit cfg_ok(input int bitwidth, input int digit);
        return (digit > 0) && (digit <= bitwidth) && ((bitwidth % digit) == 0);
    endfunction

endpackage

// File: rtl/square_digit_mac.sv
// One multiplier-digit step: acc + ((op_b * digit) << (count*DIGIT)), kept at full 2*BITWIDTH width.
module square_digit_mac #(
    parameter int BITWIDTH = 32,
    parameter int DIGIT    = 4,
    parameter int CW       = 4
) (
    input  logic [2*BITWIDTH-1:0] acc,
    input  logic [BITWIDTH-1:0]   op_b,
    input  logic [DIGIT-1:0]      digit,
    input  logic [CW-1:0]         count,
    output logic [2*BITWIDTH-1:0] acc_next
);
    localparam int AW = 2 * BITWIDTH;
    localparam int PW = BITWIDTH + DIGIT;

    logic [PW-1:0] partial;
    logic [AW-1:0] partial_ext;
    logic [31:0]   shamt;

    assign partial     = PW'(op_b) * PW'(digit);
    assign partial_ext = AW'(partial);
    assign shamt       = 32'(count) * 32'(DIGIT);
    assign acc_next    = acc + (partial_ext << shamt);

endmodule

// File: rtl/square_seq.sv
// Digit-serial squarer, DIGIT multiplier bits per cycle with early exit once the remaining x digits are zero.
// Optional macro SQUARE_SEQ_MULT_EN adds input b and computes y = x*b instead of x*x.
//
// state | meaning
// IDLE  | waiting for an operand, in_ready high
// RUN   | accumulating one multiplier digit per cycle
// DONE  | result held on y with out_valid high until out_ready
module square_seq
    import square_pkg::*;
#(
    parameter int BITWIDTH = 32,
    parameter int DIGIT    = 4
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BITWIDTH-1:0]   x,
`ifdef SQUARE_SEQ_MULT_EN
    input  logic [BITWIDTH-1:0]   b,
`endif
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*BITWIDTH-1:0] y
);
    localparam int N  = num_digits(BITWIDTH, DIGIT);
    localparam int CW = count_width(BITWIDTH, DIGIT);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    if (!cfg_ok(BITWIDTH, DIGIT)) begin : g_cfg_check
        $error("square_seq: DIGIT must be nonzero, divide BITWIDTH and not exceed it");
    end

    state_t                state;
    logic [BITWIDTH-1:0]   op_a;
    logic [BITWIDTH-1:0]   op_b;
    logic [BITWIDTH-1:0]   op_b_load;
    logic [BITWIDTH-1:0]   op_a_shift;
    logic [2*BITWIDTH-1:0] acc;
    logic [2*BITWIDTH-1:0] acc_next;
    logic [CW-1:0]         count;
    logic                  out_valid_r;
    logic [2*BITWIDTH-1:0] y_r;

`ifdef SQUARE_SEQ_MULT_EN
    assign op_b_load = b;
`else
    assign op_b_load = x;
`endif

    assign op_a_shift = op_a >> DIGIT;

    square_digit_mac #(
        .BITWIDTH (BITWIDTH),
        .DIGIT    (DIGIT),
        .CW       (CW)
    ) u_mac (
        .acc      (acc),
        .op_b     (op_b),
        .digit    (op_a[DIGIT-1:0]),
        .count    (count),
        .acc_next (acc_next)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state       <= IDLE;
            op_a        <= '0;
            op_b        <= '0;
            acc         <= '0;
            count       <= '0;
            out_valid_r <= 1'b0;
            y_r         <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_a  <= x;
                        op_b  <= op_b_load;
                        acc   <= '0;
                        count <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    acc   <= acc_next;
                    op_a  <= op_a_shift;
                    count <= count + 1'b1;
                    // Remaining high digits of x are zero: nothing left to add.
                    if (count == LAST || op_a_shift == '0) begin
                        state       <= DONE;
                        out_valid_r <= 1'b1;
                        y_r         <= acc_next;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state       <= IDLE;
                        out_valid_r <= 1'b0;
                        y_r         <= '0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    out_valid_r <= 1'b0;
                    y_r         <= '0;
                end
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = out_valid_r;
    assign y         = y_r;

endmodule

// File: tb/tb_square_seq.sv
// Self-checking bench for square_seq (32/4 main instance plus an 8/1 narrow instance).
`timescale 1ns/1ps
module tb_square_seq;
    localparam int BW = 32;
    localparam int DG = 4;

    logic            sys_clk   = 1'b0;
    logic            sys_rst_n = 1'b1;
    logic            in_valid  = 1'b0;
    logic            out_ready = 1'b0;
    logic [BW-1:0]   x         = '0;
    logic            in_ready;
    logic            out_valid;
    logic [2*BW-1:0] y;

    logic            n_in_valid  = 1'b0;
    logic            n_out_ready = 1'b1;
    logic [7:0]      n_x         = '0;
    logic            n_in_ready;
    logic            n_out_valid;
    logic [15:0]     n_y;

`ifdef SQUARE_SEQ_MULT_EN
    logic [BW-1:0]   b   = '0;
    logic [7:0]      n_b = '0;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 sys_clk = ~sys_clk;

    square_seq #(.BITWIDTH(BW), .DIGIT(DG)) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
`ifdef SQUARE_SEQ_MULT_EN
        .b         (b),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y)
    );

    square_seq #(.BITWIDTH(8), .DIGIT(1)) dut_narrow (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .in_valid  (n_in_valid),
        .in_ready  (n_in_ready),
        .x         (n_x),
`ifdef SQUARE_SEQ_MULT_EN
        .b         (n_b),
`endif
        .out_valid (n_out_valid),
        .out_ready (n_out_ready),
        .y         (n_y)
    );

    // Reference: plain full-width product of the operands as presented.
    function automatic logic [2*BW-1:0] ref_y(input logic [BW-1:0] xv, input logic [BW-1:0] bv);
`ifdef SQUARE_SEQ_MULT_EN
        return {{BW{1'b0}}, xv} * {{BW{1'b0}}, bv};
`else
        if (bv != xv) return '1;
        return {{BW{1'b0}}, xv} * {{BW{1'b0}}, xv};
`endif
    endfunction

    function automatic logic [BW-1:0] rand_operand();
        case ($urandom_range(0, 4))
            0:       return BW'($urandom) >> $urandom_range(0, BW - 1);
            1:       return ($urandom_range(0, 1) == 1) ? '1 : '0;
            default: return BW'($urandom);
        endcase
    endfunction

    // Presents one operand, then counts edges spent in RUN until out_valid rises.
    task automatic do_op(input logic [BW-1:0] xv, input logic [BW-1:0] bv,
                         output int cyc, output logic [2*BW-1:0] yv);
        bit seen;
        @(negedge sys_clk);
        in_valid = 1'b1;
        x        = xv;
`ifdef SQUARE_SEQ_MULT_EN
        b        = bv;
`endif
        @(posedge sys_clk); #1;
        in_valid = 1'b0;
        x        = ~xv;
        cyc      = 0;
        seen     = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge sys_clk); #1;
            cyc++;
            seen = out_valid;
        end
        yv = y;
    endtask

    task automatic test_reset();
        #1 sys_rst_n = 1'b0;
        #2;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %0b want 1", in_ready); else n_pass++;
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0b want 0", out_valid); else n_pass++;
        n_checks++;
        if (y !== '0) $display("FAIL reset_y: got %h want 0", y); else n_pass++;
        n_checks++;
        if (n_in_ready !== 1'b1 || n_out_valid !== 1'b0 || n_y !== '0)
            $display("FAIL reset_narrow: got rdy=%0b vld=%0b y=%h want 1 0 0", n_in_ready, n_out_valid, n_y);
        else n_pass++;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
    endtask

    task automatic test_corners();
        logic [BW-1:0]   tx [4] = '{32'hFFFF_FFFF, 32'h0, 32'h3, 32'h10};
        int              tc [4] = '{8, 1, 1, 2};
        logic [2*BW-1:0] ty [4] = '{64'hFFFF_FFFE_0000_0001, 64'h0, 64'h9, 64'h100};
        int              cyc;
        logic [2*BW-1:0] yv;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            do_op(tx[i], tx[i], cyc, yv);
            n_checks++;
            if (cyc !== tc[i]) $display("FAIL corner_run_cycles x=%h: got %0d want %0d", tx[i], cyc, tc[i]); else n_pass++;
            n_checks++;
            if (yv !== ty[i]) $display("FAIL corner_y x=%h: got %h want %h", tx[i], yv, ty[i]); else n_pass++;
            @(posedge sys_clk); #1;
            n_checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || y !== '0)
                $display("FAIL corner_one_cycle_valid x=%h: got vld=%0b rdy=%0b y=%h want 0 1 0", tx[i], out_valid, in_ready, y);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        int              cyc;
        logic [2*BW-1:0] yv;
        logic [2*BW-1:0] exp_y = 64'h014B_66DC_1DF4_D840;
        out_ready = 1'b0;
        do_op(32'h1234_5678, 32'h1234_5678, cyc, yv);
        n_checks++;
        if (yv !== exp_y) $display("FAIL bp_y: got %h want %h", yv, exp_y); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            @(negedge sys_clk);
            in_valid = 1'b1;
            x        = BW'($urandom);
            @(posedge sys_clk); #1;
            n_checks++;
            if (out_valid !== 1'b1 || y !== exp_y || in_ready !== 1'b0)
                $display("FAIL bp_hold cycle %0d: got vld=%0b y=%h rdy=%0b want 1 %h 0", i, out_valid, y, in_ready, exp_y);
            else n_pass++;
        end
        @(negedge sys_clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge sys_clk); #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || y !== '0)
            $display("FAIL bp_release: got rdy=%0b vld=%0b y=%h want 1 0 0", in_ready, out_valid, y);
        else n_pass++;
        @(posedge sys_clk); #1;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL bp_no_stray_accept: got rdy=%0b want 1", in_ready); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int              cyc;
        logic [2*BW-1:0] yv;
        bit              stray;
        out_ready = 1'b1;
        @(negedge sys_clk);
        in_valid = 1'b1;
        x        = 32'hFFFF_FFFF;
        @(posedge sys_clk); #1;
        in_valid = 1'b0;
        @(posedge sys_clk); #1;
        @(posedge sys_clk); #1;
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) $display("FAIL mid_run_busy: got rdy=%0b vld=%0b want 0 0", in_ready, out_valid); else n_pass++;
        #2 sys_rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || y !== '0 || in_ready !== 1'b1)
            $display("FAIL mid_run_reset: got vld=%0b y=%h rdy=%0b want 0 0 1", out_valid, y, in_ready);
        else n_pass++;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        stray = 1'b0;
        repeat (12) begin
            @(posedge sys_clk); #1;
            if (out_valid !== 1'b0) stray = 1'b1;
        end
        n_checks++;
        if (stray !== 1'b0) $display("FAIL mid_run_no_result: got stray out_valid=%0b want 0", stray); else n_pass++;

        out_ready = 1'b0;
        do_op(32'h0000_FFFF, 32'h0000_FFFF, cyc, yv);
        n_checks++;
        if (out_valid !== 1'b1) $display("FAIL mid_done_reached: got %0b want 1", out_valid); else n_pass++;
        #2 sys_rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || y !== '0 || in_ready !== 1'b1)
            $display("FAIL mid_done_reset: got vld=%0b y=%h rdy=%0b want 0 0 1", out_valid, y, in_ready);
        else n_pass++;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        in_valid  = 1'b1;
        x         = 32'd7;
`ifdef SQUARE_SEQ_MULT_EN
        b         = 32'd7;
`endif
        out_ready = 1'b1;
        @(posedge sys_clk); #1;
        in_valid = 1'b0;
        n_checks++;
        if (in_ready !== 1'b0) $display("FAIL first_edge_accept: got rdy=%0b want 0", in_ready); else n_pass++;
        @(posedge sys_clk); #1;
        n_checks++;
        if (out_valid !== 1'b1 || y !== 64'd49) $display("FAIL after_reset_y: got vld=%0b y=%h want 1 31", out_valid, y); else n_pass++;
        @(posedge sys_clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [2*BW-1:0] q [$];
        logic [2*BW-1:0] exp_y;
        int              sent = 0;
        int              recv = 0;
        int              cyc  = 0;
        while (recv < 1000 && cyc < 60000) begin
            @(negedge sys_clk);
            cyc++;
            in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
            x         = rand_operand();
`ifdef SQUARE_SEQ_MULT_EN
            b         = rand_operand();
            exp_y     = ref_y(x, b);
`else
            exp_y     = ref_y(x, x);
`endif
            out_ready = ($urandom_range(0, 1) == 1);
            if (in_valid && in_ready) begin
                q.push_back(exp_y);
                sent++;
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (q.size() == 0) $display("FAIL stream_spurious: got y=%h with nothing outstanding", y);
                else begin
                    exp_y = q.pop_front();
                    if (y !== exp_y) $display("FAIL stream_y #%0d: got %h want %h", recv, y, exp_y); else n_pass++;
                end
                recv++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        n_checks++;
        if (recv !== 1000 || q.size() !== 0)
            $display("FAIL stream_count: got recv=%0d pending=%0d want 1000 0", recv, q.size());
        else n_pass++;
        repeat (3) @(posedge sys_clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL stream_no_duplicate: got vld=%0b want 0", out_valid); else n_pass++;
    endtask

    task automatic test_narrow();
        logic [7:0]  tx [2] = '{8'hFF, 8'h01};
        int          tc [2] = '{8, 1};
        logic [15:0] ty [2] = '{16'hFE01, 16'h0001};
        int          cyc;
        bit          seen;
        for (int i = 0; i < 2; i++) begin
            @(negedge sys_clk);
            n_in_valid = 1'b1;
            n_x        = tx[i];
`ifdef SQUARE_SEQ_MULT_EN
            n_b        = tx[i];
`endif
            @(posedge sys_clk); #1;
            n_in_valid = 1'b0;
            cyc  = 0;
            seen = 1'b0;
            for (int k = 0; k < 20 && !seen; k++) begin
                @(posedge sys_clk); #1;
                cyc++;
                seen = n_out_valid;
            end
            n_checks++;
            if (cyc !== tc[i] || n_y !== ty[i])
                $display("FAIL narrow x=%h: got cycles=%0d y=%h want %0d %h", tx[i], cyc, n_y, tc[i], ty[i]);
            else n_pass++;
            @(posedge sys_clk); #1;
        end
    endtask

`ifdef SQUARE_SEQ_MULT_EN
    task automatic test_mult();
        int              cyc;
        logic [2*BW-1:0] yv;
        out_ready = 1'b1;
        do_op(32'h0001_0000, 32'h0001_0000, cyc, yv);
        n_checks++;
        if (cyc !== 5 || yv !== 64'h1_0000_0000)
            $display("FAIL mult_y: got cycles=%0d y=%h want 5 100000000", cyc, yv);
        else n_pass++;
        do_op(32'h0000_0003, 32'hFFFF_FFFF, cyc, yv);
        n_checks++;
        if (cyc !== 1 || yv !== ref_y(32'h3, 32'hFFFF_FFFF))
            $display("FAIL mult_early_exit: got cycles=%0d y=%h want 1 %h", cyc, yv, ref_y(32'h3, 32'hFFFF_FFFF));
        else n_pass++;
        @(posedge sys_clk); #1;
    endtask
`endif

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_corners();
        test_backpressure();
        test_reset_mid();
        test_narrow();
`ifdef SQUARE_SEQ_MULT_EN
        test_mult();
`endif
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/square_seq.md
SQUARE_SEQ -- requirements
Module: square_seq

Interface
REQ-001 SHALL have parameter BITWIDTH, default 32: operand width in bits.
REQ-002 SHALL have parameter DIGIT, default 4: multiplier bits consumed per cycle; BITWIDTH % DIGIT == 0.
REQ-003 SHALL have port sys_clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port sys_rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1: operand presented.
REQ-006 SHALL have port in_ready, output, 1: block can accept an operand.
REQ-007 SHALL have port x, input, BITWIDTH: operand, unsigned.
REQ-008 SHALL have port out_valid, output, 1: result available.
REQ-009 SHALL have port out_ready, input, 1: consumer takes the result.
REQ-010 SHALL have port y, output, 2*BITWIDTH: result, unsigned.

Function
REQ-011 SHALL be an FSM with states IDLE, RUN and DONE; N = BITWIDTH/DIGIT.
REQ-012 SHALL drive in_ready = (state == IDLE), registered-state decode only, with no combinational path from out_ready.
REQ-013 SHALL, on in_valid && in_ready, latch opA = x and opB = x, clear acc and count, and enter RUN.
REQ-014 SHALL, per RUN cycle: acc += (opB * opA[DIGIT-1:0]) << (count*DIGIT), at full 2*BITWIDTH width with no truncation; opA >>= DIGIT; count++.
REQ-015 SHALL leave RUN for DONE at the edge where count == N-1 or the post-shift opA == 0 (early termination); RUN therefore lasts 1..N cycles.
REQ-016 SHALL hold out_valid = 1 and y = acc, stable, throughout DONE.
REQ-017 SHALL return from DONE to IDLE on out_ready; out_valid deasserts the following cycle.
REQ-018 SHALL drive y = 0 whenever out_valid = 0.
REQ-019 SHALL ignore x and in_valid while not in IDLE; x is never re-sampled mid-operation.
REQ-020 SHALL keep count, with width clog2(N)+1, from wrapping; there is no operation beyond N digits.
REQ-021 SHALL produce y = x*x exactly for every x, including 0 and 2^BITWIDTH-1.
REQ-022 SHALL stay in DONE with outputs unchanged indefinitely while out_ready = 0.

Reset
REQ-023 SHALL, on sys_rst_n low and independent of sys_clk, set state to IDLE and clear opA, opB, acc and count; in_ready = 1, out_valid = 0, y = 0.
REQ-024 SHALL abort any operation in progress on a mid-RUN or mid-DONE reset, with no result emitted afterward.
REQ-025 SHALL first accept an operand on the first rising edge after sys_rst_n deasserts.

Configuration
REQ-026 SHALL support macro SQUARE_SEQ_MULT_EN; when defined, an extra input port b (BITWIDTH) is present and opB latches b, so y = x*b.
REQ-027 SHALL, with SQUARE_SEQ_MULT_EN defined, keep early termination keyed on x digits only, with identical timing rules.
REQ-028 SHALL, without the macro, omit port b and always compute y = x*x.

Structure
REQ-029 SHALL place the state enum (IDLE/RUN/DONE), the N and count-width helper functions, and the BITWIDTH % DIGIT check constant in shared package square_pkg.
REQ-030 SHALL implement the per-cycle partial product and accumulate (BITWIDTH x DIGIT multiply, shift, 2*BITWIDTH add) as sub-module square_digit_mac; the FSM and registers stay in square_seq.
REQ-031 SHALL fail elaboration when BITWIDTH % DIGIT != 0 or DIGIT > BITWIDTH.

Verification (BITWIDTH=32, DIGIT=4 unless stated)
REQ-032 x=0xFFFFFFFF, out_ready=1 -> 8 RUN cycles, y=0xFFFFFFFE00000001, out_valid for 1 cycle.
REQ-033 x=0 -> 1 RUN cycle, y=0; x=3 -> 1 RUN cycle, y=9; x=0x10 -> 2 RUN cycles, y=0x100.
REQ-034 Backpressure: x=0x12345678, out_ready=0 for 5 cycles in DONE -> y=0x014B66DC1DF4D840 stable, in_ready=0, new in_valid ignored; then out_ready=1 -> IDLE.
REQ-035 Reset mid-operation: assert sys_rst_n=0 on the 3rd RUN cycle -> immediately out_valid=0, y=0, in_ready=1; next operand x=7 -> y=49.
REQ-036 Back-to-back stream of 1000 random x with random in_valid/out_ready -> every y equals the reference x*x, in order, none dropped or duplicated.
REQ-037 SQUARE_SEQ_MULT_EN defined: x=0x10000, b=0x10000 -> y=0x100000000 after 5 RUN cycles; DIGIT=1, BITWIDTH=8 build, x=0xFF -> y=0xFE01 after 8 RUN cycles.
